// File: rtl/atmega_pio_defs.sv
// Shared definitions for the ATmega-style PIO port with pin-change interrupt.
// Holds the PCICR/PCIFR bit positions, the default register address offsets
// and a helper that builds the "bits below WIDTH" mask.
package atmega_pio_defs;

  localparam int REG_W    = 8;

  // Bit positions inside the control/flag registers
  localparam int PCIE_BIT = 0;
  localparam int PCIF_BIT = 0;

  // Default IO address offsets of the six registers
  localparam int DEF_PORT_ADDR  = 0;
  localparam int DEF_DDR_ADDR   = 1;
  localparam int DEF_PIN_ADDR   = 2;
  localparam int DEF_PCMSK_ADDR = 3;
  localparam int DEF_PCICR_ADDR = 4;
  localparam int DEF_PCIFR_ADDR = 5;

  // Ones in every bit position below w, zeros above.
  function automatic logic [REG_W-1:0] width_mask(input int w);
    logic [REG_W-1:0] m;
    m = '0;
    for (int i = 0; i < REG_W; i++) begin
      m[i] = (i < w);
    end
    return m;
  endfunction

endpackage

// File: rtl/atmega_pio_sync.sv
// Input synchroniser: WIDTH parallel flop chains, SYNC_STAGES deep, with an
// asynchronous active-low clear.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low clear of every stage
//   i_async  asynchronous pad inputs
//   o_sync   last stage of the chain
module atmega_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_chain [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_chain[s] <= '0;
      end
    end else begin
      r_chain[0] <= i_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_chain[s] <= r_chain[s-1];
      end
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/atmega_pio_pcint.sv
// ATmega-style GPIO port with WIDTH pins, write-1-to-toggle PIN register and
// a pin-change interrupt unit (mask, sticky flag, enable -> one irq line).
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   addr     IO bus address
//   wr / rd  write strobe / read strobe
//   bus_in   write data
//   bus_out  combinational read data (0 when rd=0 or in reset)
//   io_in    asynchronous pad inputs
//   io_out   pad outputs, z when not driving
//   io_oe    per-pin output enable
//   irq      pin-change interrupt request (level)
//   irq_ack  one-cycle acknowledge, clears the flag
module atmega_pio_pcint
  import atmega_pio_defs::*;
#(
  parameter int             BUS_ADDR_IO_LEN  = 16,
  parameter int             WIDTH            = 8,
  parameter int             SYNC_STAGES      = 2,
  parameter int             PORT_ADDR        = DEF_PORT_ADDR,
  parameter int             DDR_ADDR         = DEF_DDR_ADDR,
  parameter int             PIN_ADDR         = DEF_PIN_ADDR,
  parameter int             PCMSK_ADDR       = DEF_PCMSK_ADDR,
  parameter int             PCICR_ADDR       = DEF_PCICR_ADDR,
  parameter int             PCIFR_ADDR       = DEF_PCIFR_ADDR,
  parameter logic [7:0]     PINMASK          = 8'hFF,
  parameter logic [7:0]     INVERSE_MASK     = 8'h00,
  parameter logic [7:0]     OUT_ENABLED_MASK = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [7:0]                 bus_in,
  output logic [7:0]                 bus_out,
  input  logic [WIDTH-1:0]           io_in,
  output logic [WIDTH-1:0]           io_out,
  output logic [WIDTH-1:0]           io_oe,
  output logic                       irq,
  input  logic                       irq_ack
);

  // Implemented pins: below WIDTH and present in PINMASK
  localparam logic [REG_W-1:0] IMPL8 = width_mask(WIDTH) & PINMASK;
  localparam logic [WIDTH-1:0] IMPL  = IMPL8[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INV   = INVERSE_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] OEM   = OUT_ENABLED_MASK[WIDTH-1:0];

  localparam logic [BUS_ADDR_IO_LEN-1:0] A_PORT  = BUS_ADDR_IO_LEN'(PORT_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_DDR   = BUS_ADDR_IO_LEN'(DDR_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_PIN   = BUS_ADDR_IO_LEN'(PIN_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_PCMSK = BUS_ADDR_IO_LEN'(PCMSK_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_PCICR = BUS_ADDR_IO_LEN'(PCICR_ADDR);
  localparam logic [BUS_ADDR_IO_LEN-1:0] A_PCIFR = BUS_ADDR_IO_LEN'(PCIFR_ADDR);

  logic [WIDTH-1:0] r_port;
  logic [WIDTH-1:0] r_ddr;
  logic [WIDTH-1:0] r_pcmsk;
  logic [WIDTH-1:0] r_pin_prev;
  logic             r_pcie;
  logic             r_pcif;

  logic [WIDTH-1:0] w_pin;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr_port;
  logic             w_wr_ddr;
  logic             w_wr_pin;
  logic             w_wr_pcmsk;
  logic             w_wr_pcicr;
  logic             w_wr_pcifr;
  logic             w_change;
  logic             w_clr;
  logic [7:0]       w_rdata;

  atmega_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_async (io_in),
    .o_sync  (w_pin)
  );

  assign w_wdata    = bus_in[WIDTH-1:0] & IMPL;
  assign w_wr_port  = wr && (addr == A_PORT);
  assign w_wr_ddr   = wr && (addr == A_DDR);
  assign w_wr_pin   = wr && (addr == A_PIN);
  assign w_wr_pcmsk = wr && (addr == A_PCMSK);
  assign w_wr_pcicr = wr && (addr == A_PCICR);
  assign w_wr_pcifr = wr && (addr == A_PCIFR);

  // Edge detection on raw synchronised values, so inversion never hides a change
  assign w_change = |((w_pin ^ r_pin_prev) & r_pcmsk & IMPL);
  assign w_clr    = irq_ack || (w_wr_pcifr && bus_in[PCIF_BIT]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port     <= '0;
      r_ddr      <= '0;
      r_pcmsk    <= '0;
      r_pin_prev <= '0;
      r_pcie     <= 1'b0;
      r_pcif     <= 1'b0;
    end else begin
      r_pin_prev <= w_pin;
      if (w_wr_ddr)   r_ddr   <= w_wdata;
      if (w_wr_pcmsk) r_pcmsk <= w_wdata;
      if (w_wr_pcicr) r_pcie  <= bus_in[PCIE_BIT];
      if (w_wr_port) begin
        r_port <= w_wdata;
      end else if (w_wr_pin) begin
        r_port <= r_port ^ w_wdata;
      end
      // A new event beats a simultaneous clear so it is never lost
      if (w_change) begin
        r_pcif <= 1'b1;
      end else if (w_clr) begin
        r_pcif <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (rst && rd) begin
      if (addr == A_PORT) begin
        w_rdata = 8'(r_port);
      end else if (addr == A_DDR) begin
        w_rdata = 8'(r_ddr);
      end else if (addr == A_PIN) begin
        w_rdata = 8'((w_pin ^ INV) & IMPL);
      end else if (addr == A_PCMSK) begin
        w_rdata = 8'(r_pcmsk);
      end else if (addr == A_PCICR) begin
        w_rdata[PCIE_BIT] = r_pcie;
      end else if (addr == A_PCIFR) begin
        w_rdata[PCIF_BIT] = r_pcif;
      end
    end
  end

  assign bus_out = w_rdata;
  assign irq     = r_pcif & r_pcie;
  assign io_oe   = r_ddr & IMPL & OEM;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign io_out[g] = io_oe[g] ? (r_port[g] ^ INV[g]) : 1'bz;
  end

endmodule

// File: tb/tb_atmega_pio_pcint.sv
module tb_atmega_pio_pcint;

  localparam int         AW  = 16;
  localparam int         W   = 6;
  localparam int         SS  = 2;
  localparam logic [7:0] PM  = 8'h1F;   // pin 5 exists but is unimplemented
  localparam logic [7:0] INV = 8'h01;
  localparam logic [7:0] OEM = 8'hF7;   // pin 3 may not drive
  localparam logic [7:0] IMPL = PM & 8'h3F;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic          irq_ack = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [7:0]    bus_in = 8'h00;
  logic [W-1:0]  io_in = '0;
  wire  [7:0]    bus_out;
  wire  [W-1:0]  io_out;
  wire  [W-1:0]  io_oe;
  wire           irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_port, m_ddr, m_pcmsk;
  logic       m_en, m_flag;
  logic [7:0] m_hist[$];   // io_in sampled at each edge, newest first
  logic [7:0] cur_pins = 8'h00;

  always #10 clk = ~clk;

  atmega_pio_pcint #(
    .BUS_ADDR_IO_LEN  (AW),
    .WIDTH            (W),
    .SYNC_STAGES      (SS),
    .PINMASK          (PM),
    .INVERSE_MASK     (INV),
    .OUT_ENABLED_MASK (OEM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (wr),
    .rd      (rd),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oe   (io_oe),
    .irq     (irq),
    .irq_ack (irq_ack)
  );

  // Pad value as it was k edges ago (0 before enough edges since reset)
  function automatic logic [7:0] delayed(input int k);
    if (m_hist.size() >= k) return m_hist[k-1];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    case (a)
      8'd0:    return m_port;
      8'd1:    return m_ddr;
      8'd2:    return (delayed(SS) ^ INV) & IMPL;
      8'd3:    return m_pcmsk;
      8'd4:    return {7'b0, m_en};
      8'd5:    return {7'b0, m_flag};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_oe();
    logic [7:0] v;
    v = m_ddr & IMPL & OEM;
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] exp_drv();
    logic [7:0] v;
    v = (m_port ^ INV) & m_ddr & IMPL & OEM;
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    m_port = 8'h00; m_ddr = 8'h00; m_pcmsk = 8'h00;
    m_en = 1'b0; m_flag = 1'b0;
    m_hist.delete();
  endtask

  // One clock with the given bus/pad stimulus; model advances on the same edge
  task automatic cycle(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] pins, input logic ack);
    logic [7:0] pin_now, prev;
    logic       chg, clr;
    wr = w; addr = AW'(a); bus_in = d; io_in = pins[W-1:0]; irq_ack = ack;
    pin_now = delayed(SS);
    prev    = delayed(SS + 1);
    chg = |((pin_now ^ prev) & m_pcmsk & IMPL);
    clr = ack || (w && a == 8'd5 && d[0]);
    @(posedge clk);
    if (chg) m_flag = 1'b1;
    else if (clr) m_flag = 1'b0;
    if (w) begin
      case (a)
        8'd0: m_port  = d & IMPL;
        8'd1: m_ddr   = d & IMPL;
        8'd2: m_port  = m_port ^ (d & IMPL);
        8'd3: m_pcmsk = d & IMPL;
        8'd4: m_en    = d[0];
        default: ;
      endcase
    end
    m_hist.push_front(pins & 8'h3F);
    if (m_hist.size() > 8) void'(m_hist.pop_back());
    #1;
    wr = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = AW'(a); rd = 1'b1;
    #1;
    d = bus_out;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int a = 0; a < 6; a++) begin
      bus_read(8'(a), got);
      total++;
      if (got !== 8'h00) begin bad++; $display("FAIL rst_read a=%0d got=%h exp=00", a, got); end
    end
    total++;
    if (io_oe !== '0 || irq !== 1'b0) begin
      bad++; $display("FAIL rst_out io_oe=%h irq=%b exp=0/0", io_oe, irq);
    end
    rst = 1'b1;
    #1;
    for (int a = 0; a < 6; a++) begin
      bus_read(8'(a), got);
      total++;
      if (got !== exp_read(8'(a))) begin bad++; $display("FAIL post_rst_read a=%0d got=%h exp=%h", a, got, exp_read(8'(a))); end
    end
  endtask

  task automatic test_port_ddr();
    logic [7:0] got;
    cycle(1'b1, 8'd1, 8'h0F, cur_pins, 1'b0);
    cycle(1'b1, 8'd0, 8'hA5, cur_pins, 1'b0);
    total++;
    if (io_oe !== exp_oe()) begin bad++; $display("FAIL oe got=%h exp=%h", io_oe, exp_oe()); end
    total++;
    if ((io_out & io_oe) !== exp_drv()) begin bad++; $display("FAIL drive got=%h exp=%h", io_out & io_oe, exp_drv()); end
    bus_read(8'd0, got);
    total++;
    if (got !== exp_read(8'd0)) begin bad++; $display("FAIL port_rb got=%h exp=%h", got, exp_read(8'd0)); end
    bus_read(8'd1, got);
    total++;
    if (got !== exp_read(8'd1)) begin bad++; $display("FAIL ddr_rb got=%h exp=%h", got, exp_read(8'd1)); end
  endtask

  task automatic test_pin_toggle();
    logic [7:0] got;
    cycle(1'b1, 8'd2, 8'h0F, cur_pins, 1'b0);
    bus_read(8'd0, got);
    total++;
    if (got !== exp_read(8'd0)) begin bad++; $display("FAIL pin_toggle_port got=%h exp=%h", got, exp_read(8'd0)); end
    bus_read(8'd2, got);
    total++;
    if (got !== exp_read(8'd2)) begin bad++; $display("FAIL pin_unchanged got=%h exp=%h", got, exp_read(8'd2)); end
    total++;
    if (io_oe[0] !== 1'b1 || io_out[0] !== ~m_port[0]) begin
      bad++; $display("FAIL inv_out0 oe=%b out=%b exp_out=%b", io_oe[0], io_out[0], ~m_port[0]);
    end
  endtask

  task automatic test_sync();
    logic [7:0] got;
    cur_pins = 8'h00;
    idle(SS + 2);
    cur_pins = 8'h10;
    for (int k = 1; k <= SS; k++) begin
      cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
      bus_read(8'd2, got);
      total++;
      if (got !== exp_read(8'd2)) begin bad++; $display("FAIL sync_edge%0d got=%h exp=%h", k, got, exp_read(8'd2)); end
    end
  endtask

  task automatic test_pcint();
    logic [7:0] got;
    cycle(1'b1, 8'd3, 8'h10, cur_pins, 1'b0);
    cycle(1'b1, 8'd4, 8'h01, cur_pins, 1'b0);
    cycle(1'b1, 8'd5, 8'h01, cur_pins, 1'b0);
    cur_pins = cur_pins ^ 8'h10;
    for (int k = 1; k <= SS + 1; k++) begin
      cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
      bus_read(8'd5, got);
      total++;
      if (got[0] !== (k == SS + 1) || got !== exp_read(8'd5)) begin
        bad++; $display("FAIL pc_flag_edge%0d got=%h exp=%h", k, got, exp_read(8'd5));
      end
      total++;
      if (irq !== (k == SS + 1)) begin bad++; $display("FAIL pc_irq_edge%0d got=%b exp=%b", k, irq, (k == SS + 1)); end
    end
    cycle(1'b1, 8'd5, 8'h01, cur_pins, 1'b0);
    cur_pins = cur_pins ^ 8'h08;
    for (int k = 0; k < SS + 3; k++) begin
      cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL unmasked_pin3 cyc=%0d irq=%b exp=0", k, irq); end
    end
  endtask

  task automatic test_set_wins();
    logic [7:0] got;
    cur_pins = cur_pins ^ 8'h10;
    idle(SS + 2);
    cur_pins = cur_pins ^ 8'h10;
    for (int k = 0; k < SS; k++) cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
    cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b1);   // ack lands with the new change
    bus_read(8'd5, got);
    total++;
    if (got !== 8'h01 || got !== exp_read(8'd5)) begin bad++; $display("FAIL set_wins got=%h exp=01", got); end
    cycle(1'b1, 8'd4, 8'h00, cur_pins, 1'b0);
    bus_read(8'd5, got);
    total++;
    if (irq !== 1'b0 || got !== 8'h01) begin bad++; $display("FAIL en_mask irq=%b flag=%h exp=0/01", irq, got); end
    cycle(1'b1, 8'd4, 8'h01, cur_pins, 1'b0);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL en_restore irq=%b exp=1", irq); end
    cycle(1'b1, 8'd5, 8'h01, cur_pins, 1'b0);
    bus_read(8'd5, got);
    total++;
    if (got !== 8'h00 || irq !== 1'b0) begin bad++; $display("FAIL pcifr_clr flag=%h irq=%b exp=00/0", got, irq); end
  endtask

  task automatic test_masking();
    logic [7:0] got;
    idle(SS + 2);
    cycle(1'b1, 8'd0, 8'hFF, cur_pins, 1'b0);
    bus_read(8'd0, got);
    total++;
    if (got !== IMPL || got !== exp_read(8'd0)) begin bad++; $display("FAIL port_mask got=%h exp=%h", got, IMPL); end
    cycle(1'b1, 8'd3, 8'hFF, cur_pins, 1'b0);
    bus_read(8'd3, got);
    total++;
    if (got !== IMPL) begin bad++; $display("FAIL pcmsk_mask got=%h exp=%h", got, IMPL); end
    idle(3);
    bus_read(8'd5, got);
    total++;
    if (got !== 8'h00) begin bad++; $display("FAIL pcmsk_noflag got=%h exp=00", got); end
    for (int k = 0; k < 6; k++) begin
      cur_pins = cur_pins ^ 8'h20;
      cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL unimpl_pin cyc=%0d irq=%b exp=0", k, irq); end
    end
  endtask

  task automatic test_random();
    logic [7:0] got, a, wa, d;
    logic       w, ack;
    for (int n = 0; n < 400; n++) begin
      a = 8'($urandom_range(0, 7));
      bus_read(a, got);
      total++;
      if (got !== exp_read(a)) begin bad++; $display("FAIL rnd_read n=%0d a=%0d got=%h exp=%h", n, a, got, exp_read(a)); end
      total++;
      if (io_oe !== exp_oe() || (io_out & io_oe) !== exp_drv() || irq !== (m_flag & m_en)) begin
        bad++;
        $display("FAIL rnd_out n=%0d oe=%h/%h drv=%h/%h irq=%b/%b", n, io_oe, exp_oe(),
                 io_out & io_oe, exp_drv(), irq, m_flag & m_en);
      end
      w   = ($urandom_range(0, 2) == 0);
      wa  = 8'($urandom_range(0, 6));
      d   = 8'($urandom);
      ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) cur_pins = 8'($urandom) & 8'h3F;
      cycle(w, wa, d, cur_pins, ack);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    cycle(1'b1, 8'd1, 8'h1F, cur_pins, 1'b0);
    cycle(1'b1, 8'd3, 8'h1F, cur_pins, 1'b0);
    cycle(1'b1, 8'd4, 8'h01, cur_pins, 1'b0);
    cur_pins = cur_pins ^ 8'h01;
    idle(SS + 1);
    cur_pins = cur_pins ^ 8'h01;
    cycle(1'b0, 8'd0, 8'h00, cur_pins, 1'b0);
    rst = 1'b0;
    #1;
    total++;
    if (io_oe !== '0 || irq !== 1'b0) begin bad++; $display("FAIL midrst_out oe=%h irq=%b exp=0/0", io_oe, irq); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    #1;
    for (int a = 0; a < 6; a++) begin
      bus_read(8'(a), got);
      total++;
      if (got !== exp_read(8'(a))) begin bad++; $display("FAIL midrst_read a=%0d got=%h exp=%h", a, got, exp_read(8'(a))); end
    end
    idle(SS + 2);
    total++;
    if (irq !== 1'b0 || io_oe !== '0) begin bad++; $display("FAIL midrst_after irq=%b oe=%h exp=0/0", irq, io_oe); end
  endtask

  initial begin
    test_reset();
    test_port_ddr();
    test_pin_toggle();
    test_sync();
    test_pcint();
    test_set_wins();
    test_masking();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
